// File: rtl/img_rd_tx_pkg.sv
// ---------------------------------------------------------------------------
// img_rd_tx_pkg: sequencer states, UART framing constants, baud divider | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package img_rd_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_SEND_LO = 3'd4,
    ST_FIN     = 3'd5
  } seq_state_t;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   BITS_PER_FRAME = 10;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/img_rd_tx_uart_byte_tx.sv
// ---------------------------------------------------------------------------
// uart_byte_tx: 8N1 byte serializer, one bit per BAUD_DIV clocks | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_byte_tx
  import img_rd_tx_pkg::*;
#(
  parameter int BAUD_DIV = 286
) (
  input  logic       Clk_TFT,
  input  logic       Reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       uart_tx,
  output logic       tx_done,
  output logic       tx_busy
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic          active;
  logic          last_tick;
  logic          last_bit;
  logic          load;

  assign last_tick = (baud_cnt == CW'(BAUD_DIV - 1));
  assign last_bit  = (bit_cnt == 4'(BITS_PER_FRAME - 1));
  assign tx_done   = active && last_tick && last_bit;
  // Busy drops in the final stop-bit cycle so a follow-on byte loads with no gap.
  assign tx_busy   = active && !tx_done;
  assign load      = tx_start && !tx_busy;

  always_ff @(posedge Clk_TFT or negedge Reset_n) begin
    if (!Reset_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      uart_tx  <= STOP_BIT;
    end else if (load) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= {STOP_BIT, tx_data};
      uart_tx  <= START_BIT;
    end else if (active) begin
      if (last_tick) begin
        baud_cnt <= '0;
        if (last_bit) begin
          active  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          uart_tx <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/img_rd_tx.sv
// ---------------------------------------------------------------------------
// img_rd_tx: reads a frame from image RAM and sends each pixel as two UART bytes | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module img_rd_tx
  import img_rd_tx_pkg::*;
#(
  parameter int          CLK_FREQ  = 33_000_000,
  parameter int          BAUD      = 115200,
  parameter logic [15:0] LAST_ADDR = 16'hF
) (
  input  logic        Clk_TFT,
  input  logic        Reset_n,
  input  logic        start,
  output logic [15:0] ram_rdaddr,
  input  logic [15:0] ram_rddata,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);

  seq_state_t  state;
  seq_state_t  next_state;
  logic [15:0] pix_r;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        tx_busy;

  always_ff @(posedge Clk_TFT or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = ST_RD;
      ST_RD:      next_state = ST_LATCH;
      ST_LATCH:   if (!tx_busy) next_state = ST_SEND_HI;
      ST_SEND_HI: if (tx_done) next_state = ST_SEND_LO;
      ST_SEND_LO: if (tx_done) next_state = (ram_rdaddr == LAST_ADDR) ? ST_FIN : ST_RD;
      ST_FIN:     next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    tx_data  = pix_r[7:0];
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_RD:      busy = 1'b1;
      ST_LATCH: begin
        busy     = 1'b1;
        tx_start = !tx_busy;
        // pix_r is loaded on this edge, so the high byte comes straight off the RAM bus.
        tx_data  = ram_rddata[15:8];
      end
      ST_SEND_HI: begin
        busy     = 1'b1;
        tx_start = tx_done;
      end
      ST_SEND_LO: busy = 1'b1;
      ST_FIN:     done = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge Clk_TFT or negedge Reset_n) begin
    if (!Reset_n) begin
      ram_rdaddr <= '0;
      pix_r      <= '0;
    end else begin
      if (state == ST_IDLE && start)
        ram_rdaddr <= '0;
      else if (state == ST_SEND_LO && tx_done && ram_rdaddr != LAST_ADDR)
        ram_rdaddr <= ram_rdaddr + 16'd1;
      if (state == ST_LATCH)
        pix_r <= ram_rddata;
    end
  end

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_byte_tx (
    .Clk_TFT  (Clk_TFT),
    .Reset_n  (Reset_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .uart_tx  (uart_tx),
    .tx_done  (tx_done),
    .tx_busy  (tx_busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_img_rd_tx.sv
// ---------------------------------------------------------------------------
// tb_img_rd_tx: scoreboard bench decoding the UART line against RAM contents | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_img_rd_tx;

  localparam int          CLK_FREQ  = 1_000_000;
  localparam int          BAUD      = 125_000;
  localparam int          DIV       = CLK_FREQ / BAUD;
  localparam logic [15:0] LAST_ADDR = 16'hF;
  localparam int          NPIX      = 16;
  localparam int          FRAME_LAT = NPIX * (2 * 10 * DIV + 2) + 1;
  localparam int          LIMIT     = FRAME_LAT + 200;

  logic        Clk_TFT = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [15:0] ram_rdaddr;
  logic [15:0] ram_rddata = '0;
  logic        uart_tx;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;
  int bytes_rx = 0;
  int done_cnt = 0;
  int mon_cnt  = -1;
  int bidx, off;
  logic [9:0] e0, e1, mid;
  logic [7:0] q[$];

  img_rd_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .LAST_ADDR (LAST_ADDR)
  ) dut (
    .Clk_TFT    (Clk_TFT),
    .Reset_n    (Reset_n),
    .start      (start),
    .ram_rdaddr (ram_rdaddr),
    .ram_rddata (ram_rddata),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 Clk_TFT = ~Clk_TFT;

  always @(posedge Clk_TFT) ram_rddata <= mem[ram_rdaddr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk_TFT) if (done) done_cnt++;

  // Line decoder: samples each bit at its first, middle and last cycle.
  always @(negedge Clk_TFT) begin
    logic [31:0] exp_b;
    if (!Reset_n) begin
      mon_cnt = -1;
    end else begin
      if (mon_cnt < 0 && !uart_tx) mon_cnt = 0;
      if (mon_cnt >= 0) begin
        bidx = mon_cnt / DIV;
        off  = mon_cnt % DIV;
        if (off == 0)       e0[bidx]  = uart_tx;
        if (off == DIV / 2) mid[bidx] = uart_tx;
        if (off == DIV - 1) e1[bidx]  = uart_tx;
        if (mon_cnt == 10 * DIV - 1) begin
          check_eq("framing", {28'd0, mid[0], mid[9], e0 == mid, e1 == mid}, 32'b0111);
          exp_b = (q.size() > 0) ? {24'd0, q.pop_front()} : 32'h1FF;
          check_eq("byte", {24'd0, mid[8:1]}, exp_b);
          bytes_rx++;
          mon_cnt = -1;
        end else begin
          mon_cnt++;
        end
      end
    end
  end

  task automatic push_frame();
    for (int a = 0; a < NPIX; a++) begin
      q.push_back(mem[a][15:8]);
      q.push_back(mem[a][7:0]);
    end
  endtask

  task automatic run_frame(input int dup_at, output int lat, output int fall);
    bit dup_done;
    dup_done = 1'b0;
    push_frame();
    bytes_rx = 0;
    done_cnt = 0;
    start    = 1'b1;
    lat      = 0;
    fall     = -1;
    do begin
      @(negedge Clk_TFT);
      start = 1'b0;
      lat++;
      if (lat == 1) check_eq("busy_rise", {31'd0, busy}, 1);
      if (fall < 0 && !uart_tx) fall = lat;
      if (dup_at >= 0 && !dup_done && busy && ram_rdaddr == 16'(dup_at)) begin
        start    = 1'b1;
        dup_done = 1'b1;
      end
    end while (!done && lat < LIMIT);
    check_eq("frame_lat", lat, FRAME_LAT);
    check_eq("first_fall", fall, 3);
  endtask

  task automatic post_frame();
    repeat (3) @(negedge Clk_TFT);
    check_eq("q_empty", q.size(), 0);
    check_eq("byte_count", bytes_rx, 2 * NPIX);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("busy_after", {31'd0, busy}, 0);
  endtask

  initial begin
    int lat, fall, bad, guard;
    for (int a = 0; a < NPIX; a++) mem[a] = 16'(a * 16'h1111);

    repeat (3) @(negedge Clk_TFT);
    check_eq("rst_tx", {31'd0, uart_tx}, 1);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_done", {31'd0, done}, 0);
    check_eq("rst_addr", {16'd0, ram_rdaddr}, 0);
    Reset_n = 1'b1;

    bad = 0;
    repeat (10000) begin
      @(negedge Clk_TFT);
      if (!uart_tx || busy || done) bad++;
    end
    check_eq("idle_line", bad, 0);

    run_frame(-1, lat, fall);
    post_frame();

    mem[0] = 16'hA55A;
    run_frame(-1, lat, fall);
    post_frame();
    mem[0] = 16'h0000;

    run_frame(5, lat, fall);
    post_frame();
    check_eq("last_addr", {16'd0, ram_rdaddr}, {16'd0, LAST_ADDR});

    // Start in the done cycle must be dropped; start one cycle later is taken.
    run_frame(-1, lat, fall);
    check_eq("b2b_q", q.size(), 0);
    check_eq("b2b_count", bytes_rx, 2 * NPIX);
    start = 1'b1;
    @(negedge Clk_TFT);
    start = 1'b0;
    check_eq("drop_at_done", {31'd0, busy}, 0);
    run_frame(-1, lat, fall);
    post_frame();

    push_frame();
    bytes_rx = 0;
    start = 1'b1;
    @(negedge Clk_TFT);
    start = 1'b0;
    guard = 0;
    while (!(bytes_rx == 7 && mon_cnt > 4 * DIV && mon_cnt < 5 * DIV - 1) && guard < LIMIT) begin
      @(negedge Clk_TFT);
      guard++;
    end
    check_eq("reach_bit4", {31'd0, guard < LIMIT}, 1);
    Reset_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", {31'd0, uart_tx}, 1);
    check_eq("mid_rst_busy", {31'd0, busy}, 0);
    check_eq("mid_rst_addr", {16'd0, ram_rdaddr}, 0);
    q.delete();
    repeat (3) @(negedge Clk_TFT);
    Reset_n = 1'b1;
    @(negedge Clk_TFT);
    run_frame(-1, lat, fall);
    post_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
